pipe_hazard_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage core (fetch/decode/execute/memory/writeback).
//  - Detects load-use hazards and stalls fetch and decode while injecting a decode->execute bubble.
//  - Sequences wrong-path squash after a taken jump/branch.
//  - Drains the pipe on halt.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 5 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: controller state encoding and the F/D NOP opcode
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {RUN, STALL, FLUSH, DRAIN, HALTED} state_t;
  localparam logic [15:0] NOP = 16'h1000;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit counter, increments on inc, holds at all-ones, async active-high reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, taken-branch squash, halt drain and perf counters for the 5-stage core
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_MAX    = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_read,
  input  logic             ex_write_en,
  input  logic [2:0]       ex_write_reg,
  input  logic [2:0]       dec_rqrd,
  input  logic [2:0]       dec_rs,
  input  logic             dec_uses_rqrd,
  input  logic             dec_uses_rs,
  input  logic             dec_halt,
  input  logic             ex_taken,
  input  logic             wb_halt,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic             halted,
  output logic             drain_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);
  state_t state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic drain_err_q, drain_err_d;
  logic luh, stall_inc, flush_inc;
  assign luh = ex_mem_read & ex_write_en &
               ((dec_uses_rqrd & (dec_rqrd == ex_write_reg)) | (dec_uses_rs & (dec_rs == ex_write_reg)));
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    dcnt_d      = dcnt_q;
    drain_err_d = drain_err_q;
    pc_stall    = 1'b0;
    fd_stall    = 1'b0;
    fd_flush    = 1'b0;
    de_bubble   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (state_q == HALTED) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
    end else if (ex_taken) begin
      // a taken branch wins in every live state; the PC must load the target, so no pc_stall
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      flush_inc = 1'b1;
      fcnt_d    = FCNT_W'(FLUSH_CYCLES - 1);
      state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN:
          if (luh) begin
            pc_stall  = 1'b1;
            fd_stall  = 1'b1;
            de_bubble = 1'b1;
            stall_inc = 1'b1;
            state_d   = STALL;
          end else if (dec_halt) begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
            dcnt_d   = '0;
            state_d  = DRAIN;
          end
        STALL: state_d = RUN;
        FLUSH: begin
          fd_flush = 1'b1;
          fcnt_d   = fcnt_q - FCNT_W'(1);
          state_d  = (fcnt_d == '0) ? RUN : FLUSH;
        end
        DRAIN: begin
          pc_stall = 1'b1;
          fd_flush = 1'b1;
          if (wb_halt) state_d = HALTED;
          else begin
            dcnt_d      = (dcnt_q == DCNT_W'(DRAIN_MAX)) ? dcnt_q : dcnt_q + DCNT_W'(1);
            drain_err_d = drain_err_q | (dcnt_d == DCNT_W'(DRAIN_MAX));
          end
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      dcnt_q      <= '0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      dcnt_q      <= dcnt_d;
      drain_err_q <= drain_err_d;
    end
  assign halted    = (state_q == HALTED);
  assign drain_err = drain_err_q;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int FC = 2;
  localparam int DM = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ex_mem_read = 0, ex_write_en = 0, dec_uses_rqrd = 0, dec_uses_rs = 0, dec_halt = 0, ex_taken = 0, wb_halt = 0;
  logic [2:0] ex_write_reg = 0, dec_rqrd = 0, dec_rs = 0;
  logic pc_stall, fd_stall, fd_flush, de_bubble, halted, drain_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int n_chk = 0, n_fail = 0;
  int m_left, m_stall, m_drain, m_dcyc, m_halt, m_err, m_stalls, m_flushes;
  int n_left, n_stall, n_drain, n_dcyc, n_halt, n_err, n_stalls, n_flushes;
  logic [13:0] exp_v, got_v;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .DRAIN_MAX(DM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_write_en(ex_write_en),
    .ex_write_reg(ex_write_reg), .dec_rqrd(dec_rqrd), .dec_rs(dec_rs),
    .dec_uses_rqrd(dec_uses_rqrd), .dec_uses_rs(dec_uses_rs), .dec_halt(dec_halt),
    .ex_taken(ex_taken), .wb_halt(wb_halt), .pc_stall(pc_stall), .fd_stall(fd_stall),
    .fd_flush(fd_flush), .de_bubble(de_bubble), .halted(halted), .drain_err(drain_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_left = 0; m_stall = 0; m_drain = 0; m_dcyc = 0; m_halt = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic idle();
    {ex_mem_read, ex_write_en, dec_uses_rqrd, dec_uses_rs, dec_halt, ex_taken, wb_halt} = '0;
    ex_write_reg = 0; dec_rqrd = 0; dec_rs = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_clear();
    rst = 1'b0;
  endtask

  // mid-cycle: derive required outputs from the rules, compare the DUT, stage next model state
  task automatic settle();
    logic e_pc, e_fd, e_fl, e_bb, luh;
    #3;
    {e_pc, e_fd, e_fl, e_bb} = '0;
    n_left = m_left; n_stall = m_stall; n_drain = m_drain; n_dcyc = m_dcyc;
    n_halt = m_halt; n_err = m_err; n_stalls = m_stalls; n_flushes = m_flushes;
    luh = ex_mem_read && ex_write_en &&
          ((dec_uses_rqrd && dec_rqrd == ex_write_reg) || (dec_uses_rs && dec_rs == ex_write_reg));
    if (m_halt != 0) begin
      e_pc = 1; e_fd = 1;
    end else if (ex_taken) begin
      e_fl = 1; e_bb = 1;
      n_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      n_left = FC - 1; n_stall = 0; n_drain = 0;
    end else if (m_left > 0) begin
      e_fl = 1; n_left = m_left - 1;
    end else if (m_stall != 0) begin
      n_stall = 0;
    end else if (m_drain != 0) begin
      e_pc = 1; e_fl = 1;
      if (wb_halt) begin
        n_drain = 0; n_halt = 1;
      end else begin
        n_dcyc = m_dcyc + 1;
        if (n_dcyc >= DM) n_err = 1;
      end
    end else if (luh) begin
      e_pc = 1; e_fd = 1; e_bb = 1;
      n_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      n_stall = 1;
    end else if (dec_halt) begin
      e_pc = 1; e_fl = 1; n_drain = 1; n_dcyc = 0;
    end
    exp_v = {e_pc, e_fd, e_fl, e_bb, m_halt != 0, m_err != 0, CW'(m_stalls), CW'(m_flushes)};
    got_v = {pc_stall, fd_stall, fd_flush, de_bubble, halted, drain_err, stall_cnt, flush_cnt};
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL model {pc,fd,fl,bb,halt,err,scnt,fcnt}: got %b expected %b at %0t", got_v, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_left = n_left; m_stall = n_stall; m_drain = n_drain; m_dcyc = n_dcyc;
    m_halt = n_halt; m_err = n_err; m_stalls = n_stalls; m_flushes = n_flushes;
    #1;
  endtask

  task automatic set_luh();
    ex_mem_read = 1; ex_write_en = 1; ex_write_reg = 3; dec_rs = 3; dec_uses_rs = 1;
  endtask

  initial begin
    model_clear();
    idle();
    @(posedge clk); #1;
    do_reset();
    settle();
    chk("reset_outputs", {pc_stall, fd_stall, fd_flush, de_bubble, halted, drain_err}, 0);
    chk("reset_counters", {stall_cnt, flush_cnt}, 0);
    tick();
    // load-use
    set_luh();
    settle();
    chk("luh_stall", {pc_stall, fd_stall, de_bubble}, 3'b111);
    tick();
    settle();
    chk("luh_stall_release", {pc_stall, fd_stall, de_bubble}, 0);
    chk("luh_stall_cnt", stall_cnt, 1);
    tick();
    // no hazard
    dec_uses_rs = 0;
    settle();
    chk("no_haz_uses", pc_stall, 0);
    tick();
    dec_uses_rs = 1; ex_write_en = 0;
    settle();
    chk("no_haz_wen", pc_stall, 0);
    tick();
    // taken branch together with load-use
    do_reset();
    set_luh(); ex_taken = 1;
    settle();
    chk("br_luh_c0", {pc_stall, fd_flush, de_bubble}, 3'b011);
    tick();
    ex_taken = 0;
    settle();
    chk("br_luh_c1", {pc_stall, fd_flush, de_bubble}, 3'b010);
    tick();
    idle();
    settle();
    chk("br_luh_c2", fd_flush, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);
    tick();
    // halt with wb_halt three cycles later
    dec_halt = 1;
    settle();
    chk("halt_c0", {pc_stall, fd_flush}, 2'b11);
    tick();
    dec_halt = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("halt_drain", {pc_stall, halted}, 2'b10);
      tick();
    end
    wb_halt = 1;
    settle();
    chk("halt_wb", {pc_stall, halted}, 2'b10);
    tick();
    wb_halt = 0; ex_taken = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("halted_hold", {halted, pc_stall, fd_stall, fd_flush}, 4'b1110);
      tick();
    end
    // drain timeout, then an older branch rescues the drain
    idle();
    do_reset();
    dec_halt = 1;
    settle();
    tick();
    dec_halt = 0;
    for (int i = 0; i < DM; i++) begin
      settle();
      chk("drain_err_early", drain_err, 0);
      tick();
    end
    settle();
    chk("drain_err_set", drain_err, 1);
    tick();
    ex_taken = 1;
    settle();
    chk("drain_taken", {pc_stall, fd_flush, halted}, 3'b010);
    tick();
    ex_taken = 0;
    settle();
    chk("drain_flush", {fd_flush, halted, drain_err}, 3'b101);
    tick();
    settle();
    chk("drain_run", {pc_stall, fd_flush}, 0);
    tick();
    // reset mid-drain
    dec_halt = 1;
    settle();
    tick();
    dec_halt = 0;
    settle();
    tick();
    do_reset();
    settle();
    chk("rst_mid_drain", {pc_stall, fd_stall, fd_flush, de_bubble, halted, drain_err, stall_cnt, flush_cnt}, 0);
    tick();
    // saturation after 20 stalls
    for (int i = 0; i < 20; i++) begin
      set_luh();
      settle();
      tick();
      idle();
      settle();
      tick();
    end
    settle();
    chk("stall_sat", stall_cnt, CMAX);
    tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ((m_halt != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) do_reset();
      ex_mem_read   = $urandom_range(0, 1) == 1;
      ex_write_en   = $urandom_range(0, 3) != 0;
      ex_write_reg  = 3'($urandom_range(0, 3));
      dec_rqrd      = 3'($urandom_range(0, 3));
      dec_rs        = 3'($urandom_range(0, 3));
      dec_uses_rqrd = $urandom_range(0, 1) == 1;
      dec_uses_rs   = $urandom_range(0, 1) == 1;
      dec_halt      = $urandom_range(0, 9) == 0;
      ex_taken      = $urandom_range(0, 7) == 0;
      wb_halt       = $urandom_range(0, 11) == 0;
      settle();
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
